mdu_secuencial: RTL

Sequential multiply/divide unit sitting directly downstream of the register bank. It consumes the two register read operands and produces a 64-bit result in HI/LO registers over 34 cycles. It executes MULT, MULTU, DIV and DIVU from the execute stage, and holds its result until the next operation completes.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_sign_adj.sv | 17 +
 rtl/mdu_secuencial.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes,
// FSM state encoding and iteration count.
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10,
        DONE = 2'b11
    } state_t;

    // Bit 1 selects divide and bit 0 selects signed arithmetic.
    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_sign_adj.sv
// Combinational conditional two's-complement negate. When the input is a
// negative signed value, this produces its magnitude; it also applies the
// result sign.
module mdu_sign_adj
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // The most negative value maps onto itself. Read as unsigned, that is its magnitude.
    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mdu_secuencial.sv
// Sequential MULT/MULTU/DIV/DIVU unit. It iterates on operand magnitudes over
// ITER cycles, applies the sign in one more cycle, and then holds HI/LO.
module mdu_secuencial
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(ITER);

    state_t              state_reg;
    logic [1:0]          op_reg;
    logic [WIDTH-1:0]    addend_reg;
    logic [2*WIDTH-1:0]  acc_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                neg_res_reg;
    logic                neg_rem_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [WIDTH-1:0]    hi_reg;
    logic [WIDTH-1:0]    lo_reg;
    logic                dbz_reg;

    // Operand magnitudes are taken at latch time.
    logic [WIDTH-1:0] opnd [2];
    logic [WIDTH-1:0] mag  [2];
    logic             opnd_neg [2];

    assign opnd[0] = operand_a;
    assign opnd[1] = operand_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            assign opnd_neg[gi] = is_signed(op) & opnd[gi][WIDTH-1];
            mdu_sign_adj #(.WIDTH(WIDTH)) u_abs (
                .value  (opnd[gi]),
                .negate (opnd_neg[gi]),
                .result (mag[gi])
            );
        end
    endgenerate

    // Multiply step: add the addend into the upper half on lsb=1, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_reg[0] ? addend_reg : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide step: the upper half holds the remainder, the lower half shifts dividend out and quotient in.
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH+1:0]   div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    assign div_shifted = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff    = {1'b0, div_shifted} - {2'b00, addend_reg};
    assign div_fits    = ~div_diff[WIDTH+1];
    assign div_rem     = div_fits ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
    assign div_next    = {div_rem, acc_reg[WIDTH-2:0], div_fits};

    logic [2*WIDTH-1:0] acc_next;
    assign acc_next = is_div(op_reg) ? div_next : mul_next;

    // Sign application for the SIGN cycle.
    logic [2*WIDTH-1:0] prod_adj;
    logic [WIDTH-1:0]   quo_adj;
    logic [WIDTH-1:0]   rem_adj;

    mdu_sign_adj #(.WIDTH(2*WIDTH)) u_prod_adj (
        .value  (acc_reg),
        .negate (neg_res_reg),
        .result (prod_adj)
    );

    mdu_sign_adj #(.WIDTH(WIDTH)) u_quo_adj (
        .value  (acc_reg[WIDTH-1:0]),
        .negate (neg_res_reg),
        .result (quo_adj)
    );

    mdu_sign_adj #(.WIDTH(WIDTH)) u_rem_adj (
        .value  (acc_reg[2*WIDTH-1:WIDTH]),
        .negate (neg_rem_reg),
        .result (rem_adj)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            op_reg      <= OP_MULTU;
            addend_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            dbz_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg   <= op;
                        busy_reg <= 1'b1;
                        cnt_reg  <= '0;
                        if (is_div(op) && operand_b == '0) begin
                            hi_reg    <= operand_a;
                            lo_reg    <= '1;
                            dbz_reg   <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            addend_reg  <= is_div(op) ? mag[1] : mag[0];
                            acc_reg     <= {{WIDTH{1'b0}}, (is_div(op) ? mag[0] : mag[1])};
                            neg_res_reg <= opnd_neg[0] ^ opnd_neg[1];
                            neg_rem_reg <= is_div(op) & opnd_neg[0];
                            state_reg   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(ITER - 1)) begin
                        state_reg <= SIGN;
                    end
                end
                SIGN: begin
                    if (is_div(op_reg)) begin
                        hi_reg <= rem_adj;
                        lo_reg <= quo_adj;
                    end else begin
                        hi_reg <= prod_adj[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_adj[WIDTH-1:0];
                    end
                    dbz_reg   <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign div_by_zero = dbz_reg;

endmodule
